// File: rtl/div_param_amisha.sv
// rtl/div_param_amisha.sv - parametrised sequential restoring divider, signed/unsigned, dbz and ovf flags
module div_param_amisha #(
    parameter int W = 8
) (
    input  logic         clk_amisha,
    input  logic         reset_amisha,
    input  logic         start_amisha,
    input  logic         sign_amisha,
    input  logic [W-1:0] dvnd_amisha,
    input  logic [W-1:0] dvsr_amisha,
    output logic         ready_amisha,
    output logic         done_tick_amisha,
    output logic [W-1:0] quo_amisha,
    output logic [W-1:0] rmd_amisha,
    output logic         dbz_amisha,
    output logic         ovf_amisha
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, state_next;

    logic          mode_q;      // 1 = signed operation in flight
    logic          qsign_q;     // quotient must be negated in FIX
    logic          rsign_q;     // remainder must be negated in FIX
    logic [W:0]    rh_q;        // partial remainder, one guard bit for the compare
    logic [W-1:0]  rl_q;        // dividend magnitude shifting out, quotient shifting in
    logic [W-1:0]  d_q;         // divisor magnitude
    logic [CW-1:0] cnt_q;

    logic          dvnd_neg, dvsr_neg;
    logic [W-1:0]  dvnd_mag, dvsr_mag;
    logic [W+1:0]  rem_shift;
    logic          rem_ge;
    logic [W:0]    rem_next;
    logic [W-1:0]  quo_fix, rmd_fix;
    logic          ovf_fix;

    // Operand magnitudes; in signed mode -2^(W-1) maps to 2^(W-1), still W bits unsigned
    assign dvnd_neg = sign_amisha & dvnd_amisha[W-1];
    assign dvsr_neg = sign_amisha & dvsr_amisha[W-1];
    assign dvnd_mag = dvnd_neg ? -dvnd_amisha : dvnd_amisha;
    assign dvsr_mag = dvsr_neg ? -dvsr_amisha : dvsr_amisha;

    // One restoring step: shift the next dividend bit in, subtract if it fits
    always_comb begin
        rem_shift = {rh_q, rl_q[W-1]};
        rem_ge    = rem_shift >= {2'b00, d_q};
        rem_next  = rem_ge ? (W + 1)'(rem_shift - {2'b00, d_q}) : rem_shift[W:0];
    end

    // Sign correction; only signed -2^(W-1) / -1 yields a positive quotient with the MSB set
    always_comb begin
        quo_fix = qsign_q ? -rl_q : rl_q;
        rmd_fix = rsign_q ? -rh_q[W-1:0] : rh_q[W-1:0];
        ovf_fix = mode_q & ~qsign_q & rl_q[W-1];
    end

    // State register
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore handshake outputs
    always_comb begin
        state_next       = state;
        ready_amisha     = 1'b0;
        done_tick_amisha = 1'b0;
        case (state)
            IDLE: begin
                ready_amisha = 1'b1;
                if (start_amisha) begin
                    state_next = (dvsr_amisha == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == CW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX:  state_next = DONE;
            DONE: begin
                done_tick_amisha = 1'b1;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands, iterate, fix signs and publish results
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            mode_q     <= 1'b0;
            qsign_q    <= 1'b0;
            rsign_q    <= 1'b0;
            rh_q       <= '0;
            rl_q       <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            quo_amisha <= '0;
            rmd_amisha <= '0;
            dbz_amisha <= 1'b0;
            ovf_amisha <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_amisha) begin
                        mode_q <= sign_amisha;
                        if (dvsr_amisha == '0) begin
                            quo_amisha <= '1;
                            rmd_amisha <= dvnd_amisha;
                            dbz_amisha <= 1'b1;
                            ovf_amisha <= 1'b0;
                        end else begin
                            rh_q    <= '0;
                            rl_q    <= dvnd_mag;
                            d_q     <= dvsr_mag;
                            qsign_q <= dvnd_neg ^ dvsr_neg;
                            rsign_q <= dvnd_neg;
                            cnt_q   <= CW'(W);
                        end
                    end
                end
                CALC: begin
                    rh_q  <= rem_next;
                    rl_q  <= {rl_q[W-2:0], rem_ge};
                    cnt_q <= cnt_q - CW'(1);
                end
                FIX: begin
                    quo_amisha <= quo_fix;
                    rmd_amisha <= rmd_fix;
                    dbz_amisha <= 1'b0;
                    ovf_amisha <= ovf_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_param_amisha.sv
// tb/tb_div_param_amisha.sv - self-checking bench for div_param_amisha
module tb_div_param_amisha;

    localparam int W = 8;

    logic         clk_amisha = 1'b0;
    logic         reset_amisha;
    logic         start_amisha;
    logic         sign_amisha;
    logic [W-1:0] dvnd_amisha;
    logic [W-1:0] dvsr_amisha;
    logic         ready_amisha;
    logic         done_tick_amisha;
    logic [W-1:0] quo_amisha;
    logic [W-1:0] rmd_amisha;
    logic         dbz_amisha;
    logic         ovf_amisha;

    always #5 clk_amisha = ~clk_amisha;

    div_param_amisha #(.W(W)) dut (
        .clk_amisha       (clk_amisha),
        .reset_amisha     (reset_amisha),
        .start_amisha     (start_amisha),
        .sign_amisha      (sign_amisha),
        .dvnd_amisha      (dvnd_amisha),
        .dvsr_amisha      (dvsr_amisha),
        .ready_amisha     (ready_amisha),
        .done_tick_amisha (done_tick_amisha),
        .quo_amisha       (quo_amisha),
        .rmd_amisha       (rmd_amisha),
        .dbz_amisha       (dbz_amisha),
        .ovf_amisha       (ovf_amisha)
    );

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } exp_t;

    localparam int NV = 13;
    vec_t vt[NV];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready_amisha !== 1'b1 && n < 50) begin
            @(negedge clk_amisha);
            n++;
        end
        check("ready_before_start", {31'd0, ready_amisha}, 32'd1);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " scoreboard_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, " quo"}, {24'd0, quo_amisha}, {24'd0, e.q});
            check({tag, " rmd"}, {24'd0, rmd_amisha}, {24'd0, e.r});
            check({tag, " dbz"}, {31'd0, dbz_amisha}, {31'd0, e.dbz});
            check({tag, " ovf"}, {31'd0, ovf_amisha}, {31'd0, e.ovf});
        end
    endtask

    // Called right after the start edge; counts negedges until done_tick.
    // inject_at >= 0 pulses a foreign start during the operation.
    task automatic collect(input string tag, input int lat_exp, input int inject_at);
        int n = 0;
        @(negedge clk_amisha);
        while (done_tick_amisha !== 1'b1 && n < 40) begin
            if (n == inject_at) begin
                start_amisha = 1'b1;
                sign_amisha  = 1'b0;
                dvnd_amisha  = 8'd200;
                dvsr_amisha  = 8'd3;
            end else begin
                start_amisha = 1'b0;
            end
            @(negedge clk_amisha);
            n++;
        end
        start_amisha = 1'b0;
        check({tag, " latency"}, n, lat_exp);
        if (done_tick_amisha === 1'b1) compare_result(tag);
        @(negedge clk_amisha);
        check({tag, " done_pulse_width"}, {31'd0, done_tick_amisha}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t e, input int lat_exp,
                          input int inject_at);
        wait_ready();
        sign_amisha  = s;
        dvnd_amisha  = a;
        dvsr_amisha  = b;
        start_amisha = 1'b1;
        sb.push_back(e);
        @(posedge clk_amisha);
        #1;
        start_amisha = 1'b0;
        sign_amisha  = 1'($urandom);
        dvnd_amisha  = W'($urandom);
        dvsr_amisha  = W'($urandom);
        collect(tag, lat_exp, inject_at);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   m;
        int   n;
        int   seen;
        exp_t e;

        vt[0]  = '{1'b0, 8'd35,  8'd7,   8'd5,   8'd0,   1'b0, 1'b0};
        vt[1]  = '{1'b0, 8'd200, 8'd7,   8'h1C,  8'd4,   1'b0, 1'b0};
        vt[2]  = '{1'b0, 8'd255, 8'd1,   8'hFF,  8'd0,   1'b0, 1'b0};
        vt[3]  = '{1'b1, 8'hDD,  8'd4,   8'hF8,  8'hFD,  1'b0, 1'b0};
        vt[4]  = '{1'b1, 8'd35,  8'hFC,  8'hF8,  8'h03,  1'b0, 1'b0};
        vt[5]  = '{1'b1, 8'hDD,  8'hFC,  8'h08,  8'hFD,  1'b0, 1'b0};
        vt[6]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1};
        vt[7]  = '{1'b0, 8'h2A,  8'h00,  8'hFF,  8'h2A,  1'b1, 1'b0};
        vt[8]  = '{1'b1, 8'h2A,  8'h00,  8'hFF,  8'h2A,  1'b1, 1'b0};
        vt[9]  = '{1'b0, 8'd7,   8'd35,  8'd0,   8'd7,   1'b0, 1'b0};
        vt[10] = '{1'b1, 8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 1'b0};
        vt[11] = '{1'b1, 8'h80,  8'h02,  8'hC0,  8'h00,  1'b0, 1'b0};
        vt[12] = '{1'b0, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0, 1'b0};

        reset_amisha = 1'b1;
        start_amisha = 1'b0;
        sign_amisha  = 1'b0;
        dvnd_amisha  = '0;
        dvsr_amisha  = '0;
        repeat (2) @(negedge clk_amisha);
        check("reset ready", {31'd0, ready_amisha}, 32'd1);
        check("reset done_tick", {31'd0, done_tick_amisha}, 32'd0);
        check("reset quo", {24'd0, quo_amisha}, 32'd0);
        check("reset rmd", {24'd0, rmd_amisha}, 32'd0);
        check("reset dbz", {31'd0, dbz_amisha}, 32'd0);
        check("reset ovf", {31'd0, ovf_amisha}, 32'd0);
        reset_amisha = 1'b0;
        @(negedge clk_amisha);

        for (int i = 0; i < NV; i++) begin
            e = '{vt[i].q, vt[i].r, vt[i].dbz, vt[i].ovf};
            run_op($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b, e,
                   vt[i].dbz ? 0 : W + 1, -1);
        end

        // A start pulse during CALC must not disturb 35/7
        e = '{8'd5, 8'd0, 1'b0, 1'b0};
        run_op("ignored_start", 1'b0, 8'd35, 8'd7, e, W + 1, 3);
        repeat (3) @(negedge clk_amisha);
        check("ignored_start no second op", {31'd0, ready_amisha}, 32'd1);

        // Start held high: second operation begins on the first IDLE cycle
        wait_ready();
        sign_amisha  = 1'b0;
        dvnd_amisha  = 8'd35;
        dvsr_amisha  = 8'd7;
        start_amisha = 1'b1;
        sb.push_back('{8'd5, 8'd0, 1'b0, 1'b0});
        sb.push_back('{8'd5, 8'd0, 1'b0, 1'b0});
        @(posedge clk_amisha);
        n = 0;
        @(negedge clk_amisha);
        while (done_tick_amisha !== 1'b1 && n < 40) begin
            @(negedge clk_amisha);
            n++;
        end
        check("b2b first latency", n, W + 1);
        compare_result("b2b first");
        m = 0;
        @(negedge clk_amisha);
        m++;
        while (done_tick_amisha !== 1'b1 && m < 40) begin
            if (m == 2) start_amisha = 1'b0;
            @(negedge clk_amisha);
            m++;
        end
        start_amisha = 1'b0;
        check("b2b done spacing", m, W + 3);
        compare_result("b2b second");

        // Reset at iteration 4 aborts without done_tick and clears outputs
        e = '{8'h1C, 8'd4, 1'b0, 1'b0};
        run_op("pre_reset", 1'b0, 8'd200, 8'd7, e, W + 1, -1);
        wait_ready();
        sign_amisha  = 1'b0;
        dvnd_amisha  = 8'd200;
        dvsr_amisha  = 8'd7;
        start_amisha = 1'b1;
        @(posedge clk_amisha);
        #1;
        start_amisha = 1'b0;
        repeat (4) @(posedge clk_amisha);
        #2;
        reset_amisha = 1'b1;
        #1;
        check("midreset ready", {31'd0, ready_amisha}, 32'd1);
        check("midreset quo", {24'd0, quo_amisha}, 32'd0);
        check("midreset rmd", {24'd0, rmd_amisha}, 32'd0);
        check("midreset dbz", {31'd0, dbz_amisha}, 32'd0);
        check("midreset ovf", {31'd0, ovf_amisha}, 32'd0);
        @(negedge clk_amisha);
        reset_amisha = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk_amisha);
            if (done_tick_amisha === 1'b1) seen++;
        end
        check("midreset no done_tick", seen, 0);

        e = '{8'd5, 8'd0, 1'b0, 1'b0};
        run_op("after_reset", 1'b0, 8'd35, 8'd7, e, W + 1, -1);

        check("scoreboard drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
